demux_stream: RTL and testbench
===============================

# demux_stream

Registered 1-to-2 stream demultiplexer: routes each accepted input word to output port A or B according to a per-word select bit. Each port has its own small FIFO so that a stalled consumer on one port does not block words destined for the other port. This is the splitting counterpart of the team's 2-to-1 `mux` (`a`, `b`, `sel`, `outp`, `clk`). It sits where one producer fans out to two independent consumers.

## Interface
- `WIDTH`, default 4: data word width in bits.
- `DEPTH`, default 2: per-port FIFO depth in words. Must be a power of two, 2..16.
- `CNT_W`, default 8: width of the per-port accepted-word counters.

Ports (single clock, synchronous active-low reset):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  destination: 0 = port A, 1 = port B.
- `in_valid`  in  1  input word and select are valid.
- `in_ready`  out  1  the selected port can accept the word this cycle.
- `a_data`  out  WIDTH  head word of FIFO A.
- `a_valid`  out  1  FIFO A is non-empty.
- `a_ready`  in  1  consumer A takes the head word.
- `b_data`  out  WIDTH  head word of FIFO B.
- `b_valid`  out  1  FIFO B is non-empty.
- `b_ready`  in  1  consumer B takes the head word.
- `a_count`  out  CNT_W  words accepted for A since reset; wraps.
- `b_count`  out  CNT_W  words accepted for B since reset; wraps.

## Operation
- Reset values:
  - `a_valid`, `b_valid` = 0.
  - `a_data`, `b_data` = 0.
  - `a_count`, `b_count` = 0.
  - FIFO pointers and occupancy = 0.
  - All stored words are discarded.
- Reset mid-operation:
  - Buffered words are lost and no handshake completes in the reset cycle.
  - `in_ready` is 0 while `rst_n` = 0.
- `in_ready` = `rst_n` && (`in_sel` ? !full_B : !full_A).
  - This is combinational from `in_sel` and the occupancy registers.
  - It does not look at `a_ready`/`b_ready`: a full FIFO refuses a push even when a pop happens in the same cycle.
- Accept = `in_valid` && `in_ready`.
  - On accept, `in_data` is written at the write pointer of the selected FIFO.
  - That FIFO's write pointer advances modulo DEPTH.
  - The matching count increments modulo 2^CNT_W (255 -> 0 for CNT_W = 8).
- Pop on each port = valid && ready for that port. The read pointer advances modulo DEPTH.
- Occupancy update per FIFO:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- FIFOs are show-ahead: `x_data` always shows the head word.
  - `x_data` holds its last value when `x_valid` = 0.
  - `x_data` is stable while `x_valid` = 1 and `x_ready` = 0.
- Ports A and B are fully independent. Backpressure on one port never changes `in_ready` for words selected to the other port.
- Per-port order is preserved. There is no ordering guarantee between ports.
- `in_valid` = 0 causes no state change, whatever `in_sel` and `in_data` are.

## Timing
- Latency: a word accepted at edge N appears with `x_valid` = 1 in the cycle after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: one word per cycle into each port's FIFO, provided that consumer pops every cycle.
- FIFO full at DEPTH words. FIFO empty at 0 words; a pop has no effect when valid = 0.
- `a_count`/`b_count` update on the accept edge and are visible the following cycle.

## Structure
- Shared package `demux_stream_pkg`:
  - `PORT_A = 1'b0`, `PORT_B = 1'b1` select encodings.
  - Default-parameter constants.
- Sub-module `stream_fifo`, parameterised by WIDTH and DEPTH:
  - Ports: `clk`, `rst_n`, `push`, `push_data`, `full`, `pop`, `head_data`, `empty`.
  - Instantiated once per port.
  - The top level holds the select decode, the `in_ready` logic and the counters.

## Test plan
- Reset, then push `in_data`=3/`in_sel`=0 and then `in_data`=2/`in_sel`=1, with `a_ready`=`b_ready`=1:
  - `a_data`=3 with `a_valid`=1 for one cycle.
  - `b_data`=2 with `b_valid`=1 for one cycle.
  - `a_count`=1, `b_count`=1.
- Hold `a_ready`=0 and push 1, 2, 3 to A:
  - The first two are accepted.
  - `in_ready`=0 on the third.
  - Release `a_ready`: A outputs 1 then 2 in order.
- A full and stalled, then push 5 to B:
  - `in_ready`=1 and B outputs 5 the next cycle.
  - FIFO A contents are unchanged.
- A full with `a_ready`=1 and a push to A in the same cycle:
  - `in_ready`=0, so the word is refused.
  - One pop occurs and occupancy becomes 1.
- Push 256 words to A with `a_ready`=1:
  - `a_count` wraps to 0.
  - Output sequence matches the input sequence.
- Load A with 2 words, assert `rst_n`=0 for one cycle:
  - `a_valid`=0, `a_data`=0, `a_count`=0.
  - No stale word appears after reset release.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: select encodings
// and the default parameter values used by the top level.
package demux_stream_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 8;

    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/stream_fifo.sv
// Show-ahead FIFO with a registered head word that holds its last value
// once the FIFO drains.
module stream_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W:0]   w_count_next;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign head_data = r_head;

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign w_rd_next = w_pop_ok ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + (PTR_W + 1)'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_next = r_count - (PTR_W + 1)'(1);
        end
    end

    // Storage has no reset so it maps onto RAM; pointers alone discard contents.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            // The next head is the word being written when the FIFO is otherwise empty.
            if (w_count_next != '0) begin
                r_head <= (w_push_ok && (w_rd_next == r_wr_ptr)) ? push_data : r_mem[w_rd_next];
            end
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-2 stream demultiplexer: each accepted word goes to the FIFO
// of the port named by in_sel, with independent backpressure per port.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;
    logic [NUM_PORTS-1:0] w_out_ready;
    logic [WIDTH-1:0]     w_head [NUM_PORTS];
    logic [CNT_W-1:0]     r_cnt  [NUM_PORTS];
    logic                 w_accept;

    // A full FIFO refuses a push even if its consumer pops in the same cycle.
    assign in_ready = rst_n && !w_full[in_sel];
    assign w_accept = in_valid && in_ready;

    assign w_out_ready[PORT_A] = a_ready;
    assign w_out_ready[PORT_B] = b_ready;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_push[gi] = w_accept && (in_sel == 1'(gi));
            assign w_pop[gi]  = !w_empty[gi] && w_out_ready[gi];

            stream_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (w_push[gi]),
                .push_data (in_data),
                .full      (w_full[gi]),
                .pop       (w_pop[gi]),
                .head_data (w_head[gi]),
                .empty     (w_empty[gi])
            );

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt[gi] <= '0;
                end else if (w_push[gi]) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign a_data  = w_head[PORT_A];
    assign b_data  = w_head[PORT_B];
    assign a_valid = !w_empty[PORT_A];
    assign b_valid = !w_empty[PORT_B];
    assign a_count = r_cnt[PORT_A];
    assign b_count = r_cnt[PORT_B];

endmodule

// File: tb/tb_demux_stream.sv
// Randomised and directed bench for demux_stream: a queue-based model predicts
// handshakes and counts, and a separate monitor checks delivered words in order.
module tb_demux_stream;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_valid, b_valid;
    logic             a_ready, b_ready;
    logic [CNT_W-1:0] a_count, b_count;

    demux_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit done  = 1'b0;

    // Scoreboards of words expected on each port, oldest first.
    logic [WIDTH-1:0] sb_a[$];
    logic [WIDTH-1:0] sb_b[$];
    // Reference model state: occupancy and accepted-word counts.
    int               occ_a = 0, occ_b = 0;
    logic [CNT_W-1:0] cnt_a = '0, cnt_b = '0;
    logic [WIDTH-1:0] last_a = '0, last_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model / handshake checker: predicts in_ready, valids and counts.
    always @(negedge clk) begin
        if (!done) begin
            logic exp_ready;
            logic acc;
            exp_ready = rst_n && (in_sel ? (occ_b < DEPTH) : (occ_a < DEPTH));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("a_valid", 32'(a_valid), 32'(occ_a > 0));
            chk("b_valid", 32'(b_valid), 32'(occ_b > 0));
            chk("a_count", 32'(a_count), 32'(cnt_a));
            chk("b_count", 32'(b_count), 32'(cnt_b));
            if (!rst_n) begin
                occ_a = 0; occ_b = 0; cnt_a = '0; cnt_b = '0;
            end else begin
                acc = in_valid && exp_ready;
                if (occ_a > 0 && a_ready) occ_a--;
                if (occ_b > 0 && b_ready) occ_b--;
                if (acc && !in_sel) begin
                    occ_a++; cnt_a++; sb_a.push_back(in_data);
                end
                if (acc && in_sel) begin
                    occ_b++; cnt_b++; sb_b.push_back(in_data);
                end
            end
        end
    end

    // Monitor: whenever a port presents a word, it must be the oldest expected one.
    always @(negedge clk) begin
        if (!done) begin
            if (!rst_n) begin
                sb_a.delete(); sb_b.delete();
                last_a = '0; last_b = '0;
            end else begin
                if (a_valid) begin
                    if (sb_a.size() == 0) begin
                        chk("a_unexpected_word", 32'(a_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("a_data", 32'(a_data), 32'(sb_a[0]));
                        last_a = sb_a[0];
                        if (a_ready) void'(sb_a.pop_front());
                    end
                end else begin
                    chk("a_data_hold", 32'(a_data), 32'(last_a));
                end
                if (b_valid) begin
                    if (sb_b.size() == 0) begin
                        chk("b_unexpected_word", 32'(b_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("b_data", 32'(b_data), 32'(sb_b[0]));
                        last_b = sb_b[0];
                        if (b_ready) void'(sb_b.pop_front());
                    end
                end else begin
                    chk("b_data_hold", 32'(b_data), 32'(last_b));
                end
            end
        end
    end

    task automatic cyc(input logic rn, input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic ar, input logic br);
        rst_n = rn; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        // Basic routing: 3 to A, 2 to B.
        cyc(1, 1, 0, 4'd3, 1, 1);
        cyc(1, 1, 1, 4'd2, 1, 1);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 1, 4'hF, 1, 1);
        // Stall A, push 1,2,3; third refused.
        cyc(1, 1, 0, 4'd1, 0, 1);
        cyc(1, 1, 0, 4'd2, 0, 1);
        cyc(1, 1, 0, 4'd3, 0, 1);
        // A full and stalled: B still accepts.
        cyc(1, 1, 1, 4'd5, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        // A full, popping, push to A refused.
        cyc(1, 1, 0, 4'd7, 1, 1);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1, 1);
        // Counter wrap: 260 words to A.
        for (int i = 0; i < 260; i++) cyc(1, 1, 0, 4'($urandom), 1, 1);
        cyc(1, 0, 0, 0, 1, 1);
        // Load A with 2 words, then reset mid-operation.
        cyc(1, 1, 0, 4'd9, 0, 0);
        cyc(1, 1, 0, 4'd6, 0, 0);
        cyc(0, 1, 0, 4'd4, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 1);
        // Random traffic, including idle cycles with arbitrary sel/data.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 9) < 7),
                1'($urandom),
                4'($urandom),
                ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 1);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
